updown_counter: RTL and testbench

Parametrised up/down counter: the next generation of the team's 4-bit add/sub machine. It adds a configurable width and modulus, a per-cycle step size, a count enable, a synchronous parallel load, and a selectable wrap or saturate mode. It also provides registered wrap and saturation flags. It serves as the general-purpose counting primitive for timers, pointers and address generators in the design.

---
 rtl/updown_pkg.sv | 14 +
 rtl/updown_counter_if.sv | 28 ++
 rtl/updown_next.sv | 77 +++++++
 rtl/updown_counter.sv | 89 ++++++++
 tb/tb_updown_counter.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/updown_pkg.sv
// Shared types and constants for the up/down counter family.
package updown_pkg;

    // Range-boundary behaviour selected per cycle.
    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    // Count direction encodings as seen on addsub_i.
    localparam logic DIR_ADD = 1'b0;
    localparam logic DIR_SUB = 1'b1;

endpackage : updown_pkg

// File: rtl/updown_counter_if.sv
// Control and status bundle of the up/down counter.
// The master drives the controls; the counter is the slave.
interface updown_counter_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic              en_i;
    logic              addsub_i;
    logic [STEP_W-1:0] step_i;
    logic              mode_i;
    logic              load_i;
    logic [WIDTH-1:0]  load_val_i;
    logic [WIDTH-1:0]  out_o;
    logic              zero_o;
    logic              max_o;
    logic              wrap_o;
    logic              sat_o;

    modport master (
        output en_i, addsub_i, step_i, mode_i, load_i, load_val_i,
        input  out_o, zero_o, max_o, wrap_o, sat_o
    );

    modport slave (
        input  en_i, addsub_i, step_i, mode_i, load_i, load_val_i,
        output out_o, zero_o, max_o, wrap_o, sat_o
    );
endinterface : updown_counter_if

// File: rtl/updown_next.sv
// Combinational next-value calculator for one enabled count step.
// The step s is expected to be pre-clipped to MAX_VAL by the caller.
module updown_next
    import updown_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = (2**WIDTH) - 1
) (
    input  logic [WIDTH-1:0] v,
    input  logic [WIDTH-1:0] s,
    input  logic             dir,
    input  mode_e            mode,
    output logic [WIDTH-1:0] next_o,
    output logic             wrap_o,
    output logic             sat_o
);
    // One extra bit so v+s and the modulus never overflow.
    localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] MOD_EXT = MAX_EXT + {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH:0] v_ext_s;
    logic [WIDTH:0] s_ext_s;
    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] res_s;

    // Apply the step in the chosen direction and resolve boundary crossings.
    always_comb begin
        v_ext_s = {1'b0, v};
        s_ext_s = {1'b0, s};
        sum_s   = v_ext_s + s_ext_s;
        res_s   = v_ext_s;
        wrap_o  = 1'b0;
        sat_o   = 1'b0;
        if (s == '0) begin
            res_s = v_ext_s;
        end else if (dir == DIR_ADD) begin
            if (sum_s > MAX_EXT) begin
                case (mode)
                    MODE_WRAP: begin
                        res_s  = sum_s - MOD_EXT;
                        wrap_o = 1'b1;
                    end
                    MODE_SAT: begin
                        res_s = MAX_EXT;
                        sat_o = 1'b1;
                    end
                    default: begin
                        res_s = v_ext_s;
                    end
                endcase
            end else begin
                res_s = sum_s;
            end
        end else begin
            if (s_ext_s > v_ext_s) begin
                case (mode)
                    MODE_WRAP: begin
                        // Written as MOD-(s-v) so the intermediate stays in range.
                        res_s  = MOD_EXT - (s_ext_s - v_ext_s);
                        wrap_o = 1'b1;
                    end
                    MODE_SAT: begin
                        res_s = '0;
                        sat_o = 1'b1;
                    end
                    default: begin
                        res_s = v_ext_s;
                    end
                endcase
            end else begin
                res_s = v_ext_s - s_ext_s;
            end
        end
        next_o = res_s[WIDTH-1:0];
    end

endmodule : updown_next

// File: rtl/updown_counter.sv
// Parametrised up/down counter with step, enable, load and wrap/saturate modes.
module updown_counter
    import updown_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = (2**WIDTH) - 1,
    parameter int STEP_W  = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    updown_counter_if.slave    bus
);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] value_d, value_q;
    logic             wrap_d, wrap_q;
    logic             sat_d, sat_q;

    logic [WIDTH-1:0] step_ext_s;
    logic [WIDTH-1:0] step_clip_s;
    logic [WIDTH-1:0] load_clip_s;
    logic [WIDTH-1:0] nxt_val_s;
    logic             nxt_wrap_s;
    logic             nxt_sat_s;

    // Clip the step and the load value into the legal count range.
    always_comb begin
        step_ext_s = WIDTH'(bus.step_i);
        if (step_ext_s > MAX_W) begin
            step_clip_s = MAX_W;
        end else begin
            step_clip_s = step_ext_s;
        end
        if (bus.load_val_i > MAX_W) begin
            load_clip_s = MAX_W;
        end else begin
            load_clip_s = bus.load_val_i;
        end
    end

    updown_next #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_next (
        .v      (value_q),
        .s      (step_clip_s),
        .dir    (bus.addsub_i),
        .mode   (mode_e'(bus.mode_i)),
        .next_o (nxt_val_s),
        .wrap_o (nxt_wrap_s),
        .sat_o  (nxt_sat_s)
    );

    // Load beats count enable; otherwise hold with flags cleared.
    always_comb begin
        value_d = value_q;
        wrap_d  = 1'b0;
        sat_d   = 1'b0;
        if (bus.load_i) begin
            value_d = load_clip_s;
        end else if (bus.en_i) begin
            value_d = nxt_val_s;
            wrap_d  = nxt_wrap_s;
            sat_d   = nxt_sat_s;
        end else begin
            value_d = value_q;
        end
    end

    // Value and flag registers; reset overrides everything at the edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            value_q <= '0;
            wrap_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            wrap_q  <= wrap_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.out_o  = value_q;
    assign bus.zero_o = (value_q == '0);
    assign bus.max_o  = (value_q == MAX_W);
    assign bus.wrap_o = wrap_q;
    assign bus.sat_o  = sat_q;

endmodule : updown_counter

// File: tb/tb_updown_counter.sv
// Self-checking bench for updown_counter (WIDTH=4, MAX_VAL=9, STEP_W=4).
module tb_updown_counter;
    localparam int W   = 4;
    localparam int MX  = 9;
    localparam int SW  = 4;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: plain integers.
    int m_v    = 0;
    int m_wrap = 0;
    int m_sat  = 0;

    updown_counter_if #(.WIDTH(W), .STEP_W(SW)) bus ();

    updown_counter #(.WIDTH(W), .MAX_VAL(MX), .STEP_W(SW)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model of one clock edge from the counting rules.
    task automatic model_edge(input int rst, input int ld, input int lv, input int en,
                              input int dir, input int step, input int mode);
        int s;
        int t;
        s = (step > MX) ? MX : step;
        m_wrap = 0;
        m_sat  = 0;
        if (rst != 0) begin
            m_v = 0;
        end else if (ld != 0) begin
            m_v = (lv > MX) ? MX : lv;
        end else if (en != 0 && s > 0) begin
            t = (dir == 0) ? m_v + s : m_v - s;
            if (t > MX) begin
                if (mode == 0) begin m_v = t - (MX + 1); m_wrap = 1; end
                else begin m_v = MX; m_sat = 1; end
            end else if (t < 0) begin
                if (mode == 0) begin m_v = t + (MX + 1); m_wrap = 1; end
                else begin m_v = 0; m_sat = 1; end
            end else begin
                m_v = t;
            end
        end
    endtask

    // Drive one cycle, advance the model, then compare all outputs.
    task automatic cyc(input string tag, input int rst, input int ld, input int lv,
                       input int en, input int dir, input int step, input int mode);
        reset_i        = rst[0];
        bus.load_i     = ld[0];
        bus.load_val_i = lv[W-1:0];
        bus.en_i       = en[0];
        bus.addsub_i   = dir[0];
        bus.step_i     = step[SW-1:0];
        bus.mode_i     = mode[0];
        @(posedge clk_i);
        model_edge(rst, ld, lv, en, dir, step, mode);
        #1;
        check_eq({tag, ".out"},  32'(bus.out_o),  32'(m_v));
        check_eq({tag, ".zero"}, 32'(bus.zero_o), 32'(m_v == 0));
        check_eq({tag, ".max"},  32'(bus.max_o),  32'(m_v == MX));
        check_eq({tag, ".wrap"}, 32'(bus.wrap_o), 32'(m_wrap));
        check_eq({tag, ".sat"},  32'(bus.sat_o),  32'(m_sat));
    endtask

    initial begin
        // rst ld lv en dir step mode
        cyc("reset", 1, 0, 0, 0, 0, 0, 0);
        check_eq("reset.const_zero", 32'(bus.zero_o), 32'd1);

        cyc("wu_load", 0, 1, 8, 0, 0, 0, 0);
        cyc("wu_step", 0, 0, 0, 1, 0, 3, 0);
        check_eq("wu.const_out", 32'(bus.out_o), 32'd1);
        check_eq("wu.const_wrap", 32'(bus.wrap_o), 32'd1);
        cyc("wu_step2", 0, 0, 0, 1, 0, 3, 0);
        check_eq("wu2.const_out", 32'(bus.out_o), 32'd4);

        cyc("wd_load", 0, 1, 1, 0, 1, 3, 0);
        cyc("wd_step", 0, 0, 0, 1, 1, 3, 0);
        check_eq("wd.const_out", 32'(bus.out_o), 32'd8);
        cyc("wd_load5", 0, 1, 5, 0, 1, 0, 0);
        cyc("wd_clip", 0, 0, 0, 1, 1, 15, 0);
        check_eq("wd_clip.const_out", 32'(bus.out_o), 32'd6);

        cyc("sat_load", 0, 1, 2, 0, 1, 5, 1);
        cyc("sat_dn", 0, 0, 0, 1, 1, 5, 1);
        check_eq("sat_dn.const_sat", 32'(bus.sat_o), 32'd1);
        cyc("sat_hold", 0, 0, 0, 1, 1, 5, 1);
        check_eq("sat_hold.const_sat", 32'(bus.sat_o), 32'd1);
        cyc("sat_load7", 0, 1, 7, 0, 0, 2, 1);
        cyc("sat_up", 0, 0, 0, 1, 0, 2, 1);
        check_eq("sat_up.const_max", 32'(bus.max_o), 32'd1);
        check_eq("sat_up.const_sat", 32'(bus.sat_o), 32'd0);
        cyc("sat_top", 0, 0, 0, 1, 0, 1, 1);
        check_eq("sat_top.const_sat", 32'(bus.sat_o), 32'd1);

        cyc("ld_clamp", 0, 1, 12, 1, 0, 3, 0);
        check_eq("ld_clamp.const_out", 32'(bus.out_o), 32'd9);
        cyc("ld_rst", 1, 1, 5, 1, 0, 3, 0);
        check_eq("ld_rst.const_out", 32'(bus.out_o), 32'd0);

        cyc("h_load", 0, 1, 6, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc("hold_en0", 0, 0, 0, 0, i % 2, 7, 0);
        cyc("hold_s0", 0, 0, 0, 1, 0, 0, 1);
        cyc("hold_s0d", 0, 0, 0, 1, 1, 0, 0);
        check_eq("hold.const_out", 32'(bus.out_o), 32'd6);

        // Randomised run against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc("rand",
                ($urandom_range(0, 63) == 0) ? 1 : 0,
                ($urandom_range(0, 7) == 0) ? 1 : 0,
                int'($urandom_range(0, 15)),
                ($urandom_range(0, 3) != 0) ? 1 : 0,
                int'($urandom_range(0, 1)),
                int'($urandom_range(0, 15)),
                int'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_updown_counter
